// File: rtl/addsub_pkg.sv
// Shared op encodings and sequencer states for the add/sub accumulator.
package addsub_pkg;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_flags.sv
// Combinational result select and flag generation for the add/sub accumulator.
// ADDSUB_ACC_SAT_EN switches ADD/SUB results from wrap-around to unsigned saturation.
module addsub_flags
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam int MSB = WIDTH - 1;

  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (op_i)
      OP_CLR: begin
        res_o = '0;
      end
      OP_LOAD: begin
        res_o = data_i;
      end
      OP_ADD: begin
        res_o   = sum_i;
        carry_o = carry_i;
        ovf_o   = (acc_i[MSB] == data_i[MSB]) && (sum_i[MSB] != acc_i[MSB]);
`ifdef ADDSUB_ACC_SAT_EN
        if (carry_i) res_o = '1;
`endif
      end
      default: begin
        res_o   = sum_i;
        carry_o = carry_i;
        ovf_o   = (acc_i[MSB] != data_i[MSB]) && (sum_i[MSB] != acc_i[MSB]);
`ifdef ADDSUB_ACC_SAT_EN
        // carry low on SUB means a borrow: clamp at zero
        if (!carry_i) res_o = '0;
`endif
      end
    endcase
    zero_o = (res_o == '0);
  end

endmodule

// File: rtl/addsub_acc_seq.sv
// Sequenced accumulator: one command per handshake, result valid two edges after acceptance.
// Result holds until res_ready; no new command accepted meanwhile. ADDSUB_ACC_SAT_EN enables saturation.
module addsub_acc_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_ovf
);

  state_e state_q, state_d;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             sub;
  logic [WIDTH:0]   raw;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    res_valid = (state_q == HOLD);
  end

  assign accept = cmd_valid && cmd_ready;

  // SUB is acc + ~data + 1, so carry-out doubles as "no borrow"
  assign sub = (op_q == OP_SUB);
  assign raw = {1'b0, acc_q} + {1'b0, (sub ? ~data_q : data_q)} + {{WIDTH{1'b0}}, sub};

  addsub_flags #(.WIDTH(WIDTH)) u_flags (
    .acc_i   (acc_q),
    .data_i  (data_q),
    .op_i    (op_q),
    .sum_i   (raw[WIDTH-1:0]),
    .carry_i (raw[WIDTH]),
    .res_o   (acc_d),
    .carry_o (carry_d),
    .zero_o  (zero_d),
    .ovf_o   (ovf_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_CLR;
      data_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
      end
      if (state_q == EXEC) begin
        acc_q   <= acc_d;
        carry_q <= carry_d;
        zero_q  <= zero_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign res_data  = acc_q;
  assign res_carry = carry_q;
  assign res_zero  = zero_q;
  assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_addsub_acc_seq.sv
// Directed bench for addsub_acc_seq: vector table plus handshake and reset corner sequences.
module tb_addsub_acc_seq;

  localparam logic [1:0] CLR  = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] ADD  = 2'b10;
  localparam logic [1:0] SUB  = 2'b11;

`ifdef ADDSUB_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic       res_ovf;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [3:0] exp_data;
    logic       exp_carry;
    logic       exp_zero;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[16];

  addsub_acc_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .res_ovf   (res_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {res_valid, cmd_ready, res_data, carry, zero, ovf}
  function automatic logic [31:0] snap();
    return {23'd0, res_valid, cmd_ready, res_data, res_carry, res_zero, res_ovf};
  endfunction

  function automatic logic [31:0] pack(input logic v, input logic r, input logic [3:0] d,
                                       input logic c, input logic z, input logic o);
    return {23'd0, v, r, d, c, z, o};
  endfunction

  // Called just after a negedge; returns just after a negedge with the FSM in IDLE.
  task automatic do_cmd(input string name, input logic [1:0] op, input logic [3:0] d,
                        input logic [3:0] ed, input logic ec, input logic ez, input logic eo);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk({name, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({name, "_exec"}, {30'd0, res_valid, cmd_ready}, 32'b00);
      @(negedge clk);
      chk(name, snap(), pack(1'b1, 1'b0, ed, ec, ez, eo));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = CLR; cmd_data = 4'd0; res_ready = 1'b0;

    //            op    data   exp   c     z     o
    vecs[0]  = '{LOAD, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{ADD,  4'h3, 4'h8, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{SUB,  4'h8, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{CLR,  4'h7, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{LOAD, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{ADD,  4'hF, SAT ? 4'hF : 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{LOAD, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{SUB,  4'h3, SAT ? 4'h0 : 4'hE, 1'b0, SAT, 1'b0};
    vecs[8]  = '{LOAD, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{ADD,  4'h1, 4'h8, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{LOAD, 4'h8, 4'h8, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{SUB,  4'h1, 4'h7, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{LOAD, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{SUB,  4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{LOAD, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{ADD,  4'hF, SAT ? 4'hF : 4'hE, 1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", snap(), pack(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data,
             vecs[i].exp_data, vecs[i].exp_carry, vecs[i].exp_zero, vecs[i].exp_ovf);

    // Backpressure: result held while a new command waits upstream.
    do_cmd("bp_clr", CLR, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_data = 4'h3;
    @(negedge clk);
    cmd_data = 4'h1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), snap(), pack(1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_release", {30'd0, res_valid, cmd_ready}, 32'b01);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_accept", {30'd0, res_valid, cmd_ready}, 32'b00);
    @(negedge clk);
    chk("bp_result", snap(), pack(1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Reset asserted during EXEC.
    cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 4'h9;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exec", snap(), pack(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0));
    do_cmd("rst_exec_add", ADD, 4'h4, 4'h4, 1'b0, 1'b0, 1'b0);

    // Reset asserted during HOLD.
    cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 4'h9;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_hold_pre", {30'd0, res_valid, cmd_ready}, 32'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_hold", snap(), pack(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0));
    do_cmd("rst_hold_add", ADD, 4'h4, 4'h4, 1'b0, 1'b0, 1'b0);

    // res_ready while idle must not disturb anything.
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    res_ready = 1'b0;
    chk("idle_res_ready", snap(), pack(1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
